// File: rtl/ft_cmd_pkg.sv
// ft_cmd_pkg: opcodes, parser states and defaults shared by the
// FT245 command parser and host-side vector generators.
package ft_cmd_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_PHASE = 8'h01;
    localparam logic [7:0] OP_COMMIT    = 8'h02;
    localparam logic [7:0] OP_SET_ALL   = 8'h03;

    localparam int DEF_TIMEOUT_CYC = 1000000;

    typedef enum logic [2:0] {
        S_OP,
        S_ADDR,
        S_PHASE,
        S_PALL,
        S_BCAST
    } parser_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ft_cmd_parser_if.sv
// ft_cmd_parser_if: RX FIFO read side plus phase-bank write side.
// master is the parser, slave is the FIFO/phase-bank environment.
interface ft_cmd_parser_if #(
    parameter int ADDR_W  = 8,
    parameter int PHASE_W = 8
);
    logic [7:0]         rxfifo_data;
    logic               rxfifo_empty;
    logic               rxfifo_rdreq;
    logic               phase_we;
    logic [ADDR_W-1:0]  phase_addr;
    logic [PHASE_W-1:0] phase_data;
    logic               commit;
    logic               busy;
    logic [7:0]         err_count;

    modport master (
        input  rxfifo_data, rxfifo_empty,
        output rxfifo_rdreq, phase_we, phase_addr, phase_data,
        output commit, busy, err_count
    );

    modport slave (
        output rxfifo_data, rxfifo_empty,
        input  rxfifo_rdreq, phase_we, phase_addr, phase_data,
        input  commit, busy, err_count
    );
endinterface

// File: rtl/cmd_timeout.sv
// cmd_timeout: idle counter that pulses tc after TIMEOUT_CYC
// consecutive enabled cycles without a clear.
module cmd_timeout
    import ft_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    // Count idle cycles; restart on any byte, when disabled or on expiry.
    always_ff @(posedge clk) begin
        if (rst || clr || !en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ft_cmd_parser.sv
// ft_cmd_parser: decodes host command bytes from the RX FIFO into
// phase-bank writes, commit strobes and a saturating error count.
module ft_cmd_parser
    import ft_cmd_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = 8,
    parameter int PHASE_W      = 8,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic            clk,
    input  logic            rst,
    ft_cmd_parser_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CHANNELS - 1);

    parser_state_t      state;
    logic               rd_pend;
    logic               byte_vld;
    logic               rdreq;
    logic [7:0]         rx_byte;
    logic [7:0]         addr_q;
    logic [ADDR_W-1:0]  bidx;
    logic               we_q;
    logic               commit_q;
    logic [ADDR_W-1:0]  addr_o;
    logic [PHASE_W-1:0] data_o;
    logic [7:0]         err_q;
    logic               to_en;
    logic               to_tc;

    assign rx_byte  = bus.rxfifo_data;
    assign byte_vld = rd_pend;
    assign rdreq    = !bus.rxfifo_empty && !rd_pend &&
                      (state != S_BCAST) && !rst;
    assign to_en    = state inside {S_ADDR, S_PHASE, S_PALL};

    assign bus.rxfifo_rdreq = rdreq;
    assign bus.phase_we     = we_q;
    assign bus.phase_addr   = addr_o;
    assign bus.phase_data   = data_o;
    assign bus.commit       = commit_q;
    assign bus.err_count    = err_q;
    assign bus.busy         = (state != S_OP) || rd_pend;

    cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .en  (to_en),
        .clr (byte_vld),
        .tc  (to_tc)
    );

    // Read handshake, packet FSM and broadcast sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OP;
            rd_pend  <= 1'b0;
            addr_q   <= '0;
            bidx     <= '0;
            we_q     <= 1'b0;
            commit_q <= 1'b0;
            addr_o   <= '0;
            data_o   <= '0;
            err_q    <= '0;
        end else begin
            rd_pend  <= rdreq;
            we_q     <= 1'b0;
            commit_q <= 1'b0;
            if (to_tc) begin
                err_q <= sat_inc(err_q);
                state <= S_OP;
            end else begin
                unique case (state)
                    S_OP: begin
                        if (byte_vld) begin
                            unique case (rx_byte)
                                OP_NOP:       ;
                                OP_SET_PHASE: state <= S_ADDR;
                                OP_COMMIT:    commit_q <= 1'b1;
                                OP_SET_ALL:   state <= S_PALL;
                                default:      err_q <= sat_inc(err_q);
                            endcase
                        end
                    end
                    S_ADDR: begin
                        if (byte_vld) begin
                            addr_q <= rx_byte;
                            state  <= S_PHASE;
                        end
                    end
                    S_PHASE: begin
                        if (byte_vld) begin
                            if (32'(addr_q) < NUM_CHANNELS) begin
                                we_q   <= 1'b1;
                                addr_o <= ADDR_W'(addr_q);
                                data_o <= PHASE_W'(rx_byte);
                            end else begin
                                err_q <= sat_inc(err_q);
                            end
                            state <= S_OP;
                        end
                    end
                    S_PALL: begin
                        if (byte_vld) begin
                            we_q   <= 1'b1;
                            addr_o <= '0;
                            data_o <= PHASE_W'(rx_byte);
                            bidx   <= '0;
                            state  <= S_BCAST;
                        end
                    end
                    S_BCAST: begin
                        if (bidx == LAST_CH) begin
                            state <= S_OP;
                        end else begin
                            bidx   <= bidx + ADDR_W'(1);
                            addr_o <= bidx + ADDR_W'(1);
                            we_q   <= 1'b1;
                        end
                    end
                    default: state <= S_OP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ft_cmd_parser.sv
// tb_ft_cmd_parser: directed tests for ft_cmd_parser with a FIFO
// model and a negedge monitor logging writes, commits and reads.
module tb_ft_cmd_parser;
    import ft_cmd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ft_cmd_parser_if #(.ADDR_W(8), .PHASE_W(8)) bus ();

    ft_cmd_parser #(
        .NUM_CHANNELS (4),
        .ADDR_W       (8),
        .PHASE_W      (8),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.rxfifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port: data appears the cycle after rdreq.
    always @(posedge clk) begin
        if (bus.rxfifo_rdreq) begin
            bus.rxfifo_data <= mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    int we_cyc[$];
    int we_addr[$];
    int we_data[$];
    int cm_cyc[$];
    int rd_cyc[$];
    int cons_rd = 0;
    int both_hi = 0;
    logic prev_rd = 1'b0;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log strobes and reads mid-cycle.
    always @(negedge clk) begin
        if (bus.phase_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(int'(bus.phase_addr));
            we_data.push_back(int'(bus.phase_data));
        end
        if (bus.commit) cm_cyc.push_back(cyc);
        if (bus.phase_we && bus.commit) both_hi = both_hi + 1;
        if (bus.rxfifo_rdreq) rd_cyc.push_back(cyc);
        if (bus.rxfifo_rdreq && prev_rd) cons_rd = cons_rd + 1;
        prev_rd = bus.rxfifo_rdreq;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((bus.busy || !bus.rxfifo_empty) && n < max);
        check(tag, int'(n < max), 1);
        repeat (3) tick();
    endtask

    int nw0, nr0, nc0, n;

    initial begin
        do_reset();
        check("rst_we", int'(bus.phase_we), 0);
        check("rst_commit", int'(bus.commit), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err_count), 0);
        check("rst_rdreq", int'(bus.rxfifo_rdreq), 0);
        check("rst_addr", int'(bus.phase_addr), 0);

        // 1: single SET_PHASE
        nw0 = we_cyc.size(); nr0 = rd_cyc.size();
        push(OP_SET_PHASE); push(8'h02); push(8'h7F);
        wait_idle("t1_idle", 50);
        check("t1_nwe", we_cyc.size() - nw0, 1);
        check("t1_nrd", rd_cyc.size() - nr0, 3);
        check("t1_addr", we_addr[nw0], 2);
        check("t1_data", we_data[nw0], 8'h7F);
        check("t1_lat", we_cyc[nw0] - rd_cyc[nr0 + 2], 2);
        check("t1_err", int'(bus.err_count), 0);
        check("t1_busy", int'(bus.busy), 0);

        // 2: SET_ALL then COMMIT
        do_reset();
        nw0 = we_cyc.size(); nr0 = rd_cyc.size(); nc0 = cm_cyc.size();
        push(OP_SET_ALL); push(8'h40); push(OP_COMMIT);
        wait_idle("t2_idle", 50);
        check("t2_nwe", we_cyc.size() - nw0, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", we_addr[nw0 + i], i);
            check("t2_data", we_data[nw0 + i], 8'h40);
            check("t2_cyc", we_cyc[nw0 + i], rd_cyc[nr0 + 1] + 2 + i);
        end
        check("t2_rd_gap", rd_cyc[nr0 + 2], we_cyc[nw0 + 3] + 1);
        check("t2_ncm", cm_cyc.size() - nc0, 1);
        check("t2_cm_lat", cm_cyc[nc0] - rd_cyc[nr0 + 2], 2);

        // 3: bad address then unknown opcode
        do_reset();
        nw0 = we_cyc.size();
        push(OP_SET_PHASE); push(8'h05); push(8'h11); push(8'h55);
        wait_idle("t3_idle", 50);
        check("t3_nwe", we_cyc.size() - nw0, 0);
        check("t3_err", int'(bus.err_count), 2);
        check("t3_busy", int'(bus.busy), 0);

        // 4: timeout mid-packet
        do_reset();
        nw0 = we_cyc.size();
        push(OP_SET_PHASE);
        repeat (10) tick();
        check("t4_err_early", int'(bus.err_count), 0);
        check("t4_busy_early", int'(bus.busy), 1);
        repeat (10) tick();
        check("t4_err", int'(bus.err_count), 1);
        check("t4_busy", int'(bus.busy), 0);
        push(OP_SET_PHASE); push(8'h00); push(8'hAA);
        wait_idle("t4_idle", 50);
        check("t4_nwe", we_cyc.size() - nw0, 1);
        check("t4_addr", we_addr[nw0], 0);
        check("t4_data", we_data[nw0], 8'hAA);
        check("t4_err_after", int'(bus.err_count), 1);

        // 5: error counter saturation
        do_reset();
        nw0 = we_cyc.size();
        for (int i = 0; i < 300; i++) push(8'hFF);
        wait_idle("t5_idle", 1000);
        check("t5_err", int'(bus.err_count), 255);
        check("t5_nwe", we_cyc.size() - nw0, 0);
        check("t5_cons_rd", cons_rd, 0);

        // 6: reset during broadcast
        do_reset();
        nw0 = we_cyc.size(); nc0 = cm_cyc.size();
        push(OP_SET_ALL); push(8'h20);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.phase_we && bus.phase_addr == 8'd1) && n < 50);
        check("t6_reach", int'(n < 50), 1);
        rst = 1'b1;
        tick();
        check("t6_we", int'(bus.phase_we), 0);
        check("t6_commit", int'(bus.commit), 0);
        check("t6_busy", int'(bus.busy), 0);
        check("t6_err", int'(bus.err_count), 0);
        check("t6_addr", int'(bus.phase_addr), 0);
        check("t6_data", int'(bus.phase_data), 0);
        check("t6_rdreq", int'(bus.rxfifo_rdreq), 0);
        rst = 1'b0;
        repeat (5) tick();
        check("t6_nwe", we_cyc.size() - nw0, 2);
        push(OP_COMMIT);
        wait_idle("t6_idle", 50);
        check("t6_ncm", cm_cyc.size() - nc0, 1);
        check("t6_nwe_after", we_cyc.size() - nw0, 2);
        check("we_commit_overlap", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
